except_ctrl: RTL

EXCEPT_CTRL -- requirements
Module: except_ctrl

---
 rtl/except_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/except_ctrl.sv
// Exception controller: picks the highest-priority MEM-stage exception, reports it to CP0,
// waits for the acknowledge (re-reporting after a timeout) and then redirects the front end.
module except_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter logic [4:0]  NONE_CODE  = 5'h1F,
    parameter int          ACK_WAIT   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_ds,
    input  logic        f_adel,
    input  logic        f_ri,
    input  logic        f_ov,
    input  logic        f_sys,
    input  logic        f_bp,
    input  logic        f_eret,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic        except_deal,
    input  logic [31:0] cp0_epc,
    output logic [4:0]  exc_code,
    output logic [31:0] bad_addr,
    output logic        delay_slot,
    output logic [31:0] exc_pc,
    output logic        stall,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] new_pc
);

    // Handshake: CP0 sees exc_code != NONE_CODE for exactly one cycle (REPORT) and answers
    // with a one-cycle except_deal pulse while stall is held; except_deal seen in IDLE is an
    // interrupt and redirects straight to EXC_VECTOR.
    typedef enum logic [1:0] {
        S_IDLE,
        S_REPORT,
        S_WAIT,
        S_REDIRECT
    } state_t;

    localparam logic [4:0] C_ADEL = 5'h04;
    localparam logic [4:0] C_ADES = 5'h05;
    localparam logic [4:0] C_SYS  = 5'h08;
    localparam logic [4:0] C_BP   = 5'h09;
    localparam logic [4:0] C_RI   = 5'h0A;
    localparam logic [4:0] C_OV   = 5'h0C;
    localparam logic [4:0] C_ERET = 5'h0E;
    localparam logic [7:0] ACK_LIM = 8'(ACK_WAIT);

    state_t      state, state_d;
    logic [4:0]  code_q, code_d;
    logic        eret_q, eret_d;
    logic [7:0]  timer, timer_d;
    logic [31:0] bad_d, pc_d, newpc_d;
    logic        ds_d;

    logic        misaligned;
    logic        det;
    logic        det_eret;
    logic        det_bad_load;
    logic [4:0]  det_code;
    logic [31:0] det_bad;

    always_comb begin
        unique case (mem_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = mem_addr[0];
            default: misaligned = (mem_addr[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        det          = 1'b0;
        det_eret     = 1'b0;
        det_bad_load = 1'b0;
        det_code     = NONE_CODE;
        det_bad      = mem_addr;
        if (mem_valid) begin
            if (f_adel) begin
                det = 1'b1; det_code = C_ADEL; det_bad_load = 1'b1; det_bad = mem_pc;
            end else if (f_ri) begin
                det = 1'b1; det_code = C_RI;
            end else if (f_ov) begin
                det = 1'b1; det_code = C_OV;
            end else if (f_sys) begin
                det = 1'b1; det_code = C_SYS;
            end else if (f_bp) begin
                det = 1'b1; det_code = C_BP;
            end else if (f_eret) begin
                det = 1'b1; det_code = C_ERET; det_eret = 1'b1;
            end else if (mem_rd && misaligned) begin
                det = 1'b1; det_code = C_ADEL; det_bad_load = 1'b1;
            end else if (mem_wr && misaligned) begin
                det = 1'b1; det_code = C_ADES; det_bad_load = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state;
        code_d  = code_q;
        eret_d  = eret_q;
        timer_d = timer;
        bad_d   = bad_addr;
        pc_d    = exc_pc;
        ds_d    = delay_slot;
        newpc_d = new_pc;
        unique case (state)
            S_IDLE: begin
                pc_d = mem_pc;
                ds_d = mem_in_ds;
                if (except_deal) begin
                    // Interrupt wins; a same-cycle exception is dropped and refetched later.
                    state_d = S_REDIRECT;
                    eret_d  = 1'b0;
                    newpc_d = EXC_VECTOR;
                end else if (det) begin
                    state_d = S_REPORT;
                    code_d  = det_code;
                    eret_d  = det_eret;
                    if (det_bad_load) bad_d = det_bad;
                end
            end
            S_REPORT: begin
                state_d = S_WAIT;
                timer_d = 8'd0;
            end
            S_WAIT: begin
                if (except_deal) begin
                    state_d = S_REDIRECT;
                    newpc_d = eret_q ? cp0_epc : EXC_VECTOR;
                end else begin
                    timer_d = timer + 8'd1;
                    if (timer + 8'd1 == ACK_LIM) state_d = S_REPORT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            code_q     <= NONE_CODE;
            eret_q     <= 1'b0;
            timer      <= 8'd0;
            exc_code   <= NONE_CODE;
            bad_addr   <= 32'd0;
            exc_pc     <= 32'd0;
            new_pc     <= 32'd0;
            delay_slot <= 1'b0;
            stall      <= 1'b0;
            flush      <= 1'b0;
            redirect   <= 1'b0;
        end else begin
            state      <= state_d;
            code_q     <= code_d;
            eret_q     <= eret_d;
            timer      <= timer_d;
            bad_addr   <= bad_d;
            exc_pc     <= pc_d;
            delay_slot <= ds_d;
            new_pc     <= newpc_d;
            exc_code   <= (state_d == S_REPORT) ? code_d : NONE_CODE;
            stall      <= (state_d == S_REPORT) || (state_d == S_WAIT);
            flush      <= (state_d == S_REDIRECT);
            redirect   <= (state_d == S_REDIRECT);
        end
    end

endmodule
